// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch stage; owns the PC, keeps one imem request in
//            flight and hands {instr, pc} to IF/ID with stall and redirect.
// Revision : 1.0
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_req_pc;
    logic [31:0] w_req_pc_next;
    logic        r_fetch_valid;
    logic [31:0] r_fetch_instr;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_redirect_pc;
    logic        w_out_busy;
    logic        w_issue;
    logic        w_load;
    logic        w_clear;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_out_busy    = r_fetch_valid && stall;
    // Only issue when the output register is free, so a response never lands on held data.
    assign w_issue       = (r_state == ST_REQ) && !redirect_valid && !w_out_busy;
    assign w_clear       = redirect_valid || (r_fetch_valid && !stall);

    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_req_pc_next = r_req_pc;
        w_load        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_REQ;
                if (redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end
            end
            ST_REQ: begin
                if (redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end else if (w_issue && imem_ready) begin
                    w_req_pc_next = r_pc;
                    w_state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = ST_REQ;
                    if (redirect_valid) begin
                        w_pc_next = w_redirect_pc;
                    end else begin
                        w_load    = 1'b1;
                        w_pc_next = r_req_pc + PC_STEP;
                    end
                end else if (redirect_valid) begin
                    w_pc_next    = w_redirect_pc;
                    w_state_next = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end
                if (imem_rvalid) begin
                    w_state_next = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_req_pc <= 32'h0000_0000;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_req_pc <= w_req_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= BUBBLE_INSTR;
            r_fetch_pc    <= 32'h0000_0000;
        end else if (w_load) begin
            r_fetch_valid <= 1'b1;
            r_fetch_instr <= imem_rdata;
            r_fetch_pc    <= r_req_pc;
        end else if (w_clear) begin
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= BUBBLE_INSTR;
            r_fetch_pc    <= 32'h0000_0000;
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign fetch_instr = r_fetch_instr;
    assign fetch_pc    = r_fetch_pc;

endmodule
`default_nettype wire
